wb_load_stage: RTL and testbench

WB_LOAD_STAGE -- requirements
Module: wb_load_stage

---
 rtl/wb_load_stage.sv | 182 ++++++++++++++++++
 tb/tb_wb_load_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_load_stage.sv
// Writeback stage: ALU results and HI/LO pass straight through. A load waits for
// the data bus, is extended by its byte-select, and commits one cycle later.
module wb_load_stage (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_wa_i,
  input  logic        wb_wreg_i,
  input  logic [31:0] wb_dreg_i,
  input  logic        wb_mreg_i,
  input  logic [3:0]  wb_dre_i,
  input  logic        wb_msext_i,
  input  logic        wb_whilo_i,
  input  logic [63:0] wb_hilo_i,
  input  logic        wb_whi_i,
  input  logic        wb_wlo_i,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        flush_i,
  output logic [4:0]  wb_wa_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wd_o,
  output logic        wb_hi_we_o,
  output logic        wb_lo_we_o,
  output logic [31:0] wb_hi_o,
  output logic [31:0] wb_lo_o,
  output logic        wb_stall_o,
  output logic [1:0]  wb_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    COMMIT = 2'b10,
    DRAIN  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  wa_q, wa_d;
  logic [3:0]  dre_q, dre_d;
  logic        msext_q, msext_d;
  logic [31:0] ld_buf_q, ld_buf_d;
  logic        rst_q;

  logic        load_in;
  logic        commit_we;
  logic        load_stall;
  logic        block_we;
  logic        pass_we;
  logic [3:0]  ext_dre;
  logic        ext_zext;
  logic [31:0] ext_data;

  // Unlisted byte-select codes yield zero rather than a partial lane mix.
  function automatic logic [31:0] extract_load(input logic [3:0]  dre,
                                               input logic        zext,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = '0;
    h = '0;
    r = '0;
    case (dre)
      4'b1000: begin b = rdata[7:0];   r = {{24{~zext & b[7]}}, b}; end
      4'b0100: begin b = rdata[15:8];  r = {{24{~zext & b[7]}}, b}; end
      4'b0010: begin b = rdata[23:16]; r = {{24{~zext & b[7]}}, b}; end
      4'b0001: begin b = rdata[31:24]; r = {{24{~zext & b[7]}}, b}; end
      4'b1100: begin h = rdata[15:0];  r = {{16{~zext & h[15]}}, h}; end
      4'b0011: begin h = rdata[31:16]; r = {{16{~zext & h[15]}}, h}; end
      4'b1111: r = rdata;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign load_in = wb_valid_i & wb_mreg_i;

  // A same-cycle response in IDLE must be decoded with the incoming fields,
  // since the latched copies are only written at the end of this cycle.
  assign ext_dre  = (state_q == IDLE) ? wb_dre_i   : dre_q;
  assign ext_zext = (state_q == IDLE) ? wb_msext_i : msext_q;
  assign ext_data = extract_load(ext_dre, ext_zext, data_rdata);

  always_comb begin
    state_d    = state_q;
    wa_d       = wa_q;
    dre_d      = dre_q;
    msext_d    = msext_q;
    ld_buf_d   = ld_buf_q;
    commit_we  = 1'b0;
    load_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_in) begin
          load_stall = 1'b1;
          if (flush_i) begin
            // Killed load may still have a bus response in flight; swallow it.
            state_d = data_data_ok ? IDLE : DRAIN;
          end else begin
            wa_d    = wb_wa_i;
            dre_d   = wb_dre_i;
            msext_d = wb_msext_i;
            if (data_data_ok) begin
              ld_buf_d = ext_data;
              state_d  = COMMIT;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        load_stall = 1'b1;
        if (flush_i) begin
          state_d = data_data_ok ? IDLE : DRAIN;
        end else if (data_data_ok) begin
          ld_buf_d = ext_data;
          state_d  = COMMIT;
        end
      end
      COMMIT: begin
        commit_we = ~flush_i;
        state_d   = IDLE;
      end
      DRAIN: begin
        load_stall = 1'b1;
        if (!flush_i && data_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q  <= IDLE;
      wa_q     <= '0;
      dre_q    <= '0;
      msext_q  <= 1'b0;
      ld_buf_q <= '0;
      rst_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      wa_q     <= wa_d;
      dre_q    <= dre_d;
      msext_q  <= msext_d;
      ld_buf_q <= ld_buf_d;
      rst_q    <= 1'b0;
    end
  end

  // Writes are blocked during reset, the cycle right after it, and on flush.
  assign block_we = cpu_rst | rst_q | flush_i;
  assign pass_we  = (state_q == IDLE) & wb_valid_i & wb_wreg_i & ~wb_mreg_i;

  always_comb begin
    wb_wreg_o  = ~block_we & (pass_we | commit_we);
    wb_wa_o    = wb_wa_i;
    wb_wd_o    = wb_dreg_i;
    wb_hi_we_o = ~block_we & wb_valid_i & (wb_whilo_i | wb_whi_i);
    wb_lo_we_o = ~block_we & wb_valid_i & (wb_whilo_i | wb_wlo_i);
    wb_hi_o    = wb_hilo_i[63:32];
    wb_lo_o    = wb_hilo_i[31:0];
    wb_stall_o = load_stall;
    wb_state_o = state_q;
    if (state_q == COMMIT) begin
      wb_wa_o = wa_q;
      wb_wd_o = ld_buf_q;
    end
    if (cpu_rst) begin
      wb_wa_o    = '0;
      wb_wd_o    = '0;
      wb_hi_o    = '0;
      wb_lo_o    = '0;
      wb_stall_o = 1'b0;
      wb_state_o = IDLE;
    end
  end

endmodule

// File: tb/tb_wb_load_stage.sv
// Directed scenarios followed by random traffic, checked against a flag-based
// model of the pending-load life cycle.
module tb_wb_load_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, wreg, mreg, msext, whilo, whi, wlo, ok, flush;
  logic [4:0]  wa;
  logic [31:0] dreg, rdata;
  logic [3:0]  dre;
  logic [63:0] hilo;
  logic [4:0]  wa_o;
  logic        wreg_o, hi_we_o, lo_we_o, stall_o;
  logic [31:0] wd_o, hi_o, lo_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  // model: pending-load flags plus the captured load
  bit          m_wait, m_drain, m_commit, m_post;
  logic [4:0]  m_wa;
  logic [3:0]  m_dre;
  logic        m_zext;
  logic [31:0] m_data;

  // sampled observations from the last cycle()
  logic        s_we, s_stall, s_hi_we, s_lo_we;
  logic [4:0]  s_wa;
  logic [31:0] s_wd, s_hi;
  logic [1:0]  s_state;

  always #5 clk = ~clk;

  wb_load_stage dut (
    .cpu_clk_50M(clk), .cpu_rst(rst),
    .wb_valid_i(valid), .wb_wa_i(wa), .wb_wreg_i(wreg), .wb_dreg_i(dreg),
    .wb_mreg_i(mreg), .wb_dre_i(dre), .wb_msext_i(msext),
    .wb_whilo_i(whilo), .wb_hilo_i(hilo), .wb_whi_i(whi), .wb_wlo_i(wlo),
    .data_data_ok(ok), .data_rdata(rdata), .flush_i(flush),
    .wb_wa_o(wa_o), .wb_wreg_o(wreg_o), .wb_wd_o(wd_o),
    .wb_hi_we_o(hi_we_o), .wb_lo_we_o(lo_we_o), .wb_hi_o(hi_o), .wb_lo_o(lo_o),
    .wb_stall_o(stall_o), .wb_state_o(state_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_extract(input logic [3:0] d, input logic zext,
                                              input logic [31:0] r);
    logic [31:0] v;
    int lane, width;
    lane = 0; width = 0; v = 0;
    case (d)
      4'b1000: begin lane = 0; width = 8;  end
      4'b0100: begin lane = 1; width = 8;  end
      4'b0010: begin lane = 2; width = 8;  end
      4'b0001: begin lane = 3; width = 8;  end
      4'b1100: begin lane = 0; width = 16; end
      4'b0011: begin lane = 2; width = 16; end
      4'b1111: begin lane = 0; width = 32; end
      default: width = 0;
    endcase
    if (width == 8) begin
      v = (r >> (8 * lane)) & 32'hFF;
      if (!zext && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (width == 16) begin
      v = (r >> (8 * lane)) & 32'hFFFF;
      if (!zext && v >= 32768) v = v + 32'hFFFF_0000;
    end else if (width == 32) begin
      v = r;
    end
    return v;
  endfunction

  task automatic clear_inputs();
    valid = 0; wreg = 0; mreg = 0; msext = 0; whilo = 0; whi = 0; wlo = 0;
    ok = 0; flush = 0; wa = 0; dreg = 0; rdata = 0; dre = 0; hilo = 0;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit idle, e_we, e_hiwe, e_lowe, e_stall;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [1:0]  e_state;
    @(negedge clk);
    idle = !m_wait && !m_drain && !m_commit;
    if (rst) begin
      e_we = 0; e_hiwe = 0; e_lowe = 0; e_stall = 0; e_state = 2'd0;
      e_wa = 0; e_wd = 0;
    end else begin
      e_we    = !(m_post || flush) && ((idle && valid && wreg && !mreg) || m_commit);
      e_wa    = m_commit ? m_wa : wa;
      e_wd    = m_commit ? m_data : dreg;
      e_hiwe  = !(m_post || flush) && valid && (whilo || whi);
      e_lowe  = !(m_post || flush) && valid && (whilo || wlo);
      e_stall = m_wait || m_drain || (idle && valid && mreg);
      e_state = m_commit ? 2'd2 : m_drain ? 2'd3 : m_wait ? 2'd1 : 2'd0;
    end
    s_we = wreg_o; s_wa = wa_o; s_wd = wd_o; s_stall = stall_o;
    s_hi_we = hi_we_o; s_lo_we = lo_we_o; s_hi = hi_o; s_state = state_o;
    chk("wreg", wreg_o, e_we);
    chk("stall", stall_o, e_stall);
    chk("state", state_o, e_state);
    chk("hi_we", hi_we_o, e_hiwe);
    chk("lo_we", lo_we_o, e_lowe);
    if (e_we || rst) begin
      chk("wa", wa_o, e_wa);
      chk("wd", wd_o, e_wd);
    end
    if (rst) begin
      chk("hi_rst", hi_o, 0);
      chk("lo_rst", lo_o, 0);
    end else if (valid) begin
      chk("hi", hi_o, hilo[63:32]);
      chk("lo", lo_o, hilo[31:0]);
    end
    $display("t=%0t rst=%0b st=%0d stall=%0b we=%0b wa=%0d wd=%h", $time, rst,
             state_o, stall_o, wreg_o, wa_o, wd_o);
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_drain = 0; m_commit = 0; m_post = 1;
      m_wa = 0; m_dre = 0; m_zext = 0; m_data = 0;
    end else begin
      m_post = 0;
      if (m_commit) begin
        m_commit = 0;
      end else if (m_wait) begin
        if (flush) begin
          m_wait = 0; m_drain = !ok;
        end else if (ok) begin
          m_wait = 0; m_commit = 1; m_data = ref_extract(m_dre, m_zext, rdata);
        end
      end else if (m_drain) begin
        if (!flush && ok) m_drain = 0;
      end else if (valid && mreg) begin
        if (flush) begin
          m_drain = !ok;
        end else begin
          m_wa = wa; m_dre = dre; m_zext = msext;
          if (ok) begin
            m_commit = 1; m_data = ref_extract(dre, msext, rdata);
          end else begin
            m_wait = 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic set_load(input logic [4:0] a, input logic [3:0] d, input logic z);
    clear_inputs();
    valid = 1; wreg = 1; mreg = 1; wa = a; dre = d; msext = z;
  endtask

  initial begin
    int stall_cnt;
    logic [3:0] dre_tab [8];
    dre_tab = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b0011, 4'b1111, 4'b0110};

    clear_inputs();
    rst = 1;
    cycle();
    chk("rst_state", s_state, 2'd0);
    chk("rst_wd", s_wd, 32'h0);
    rst = 0;
    valid = 1; wreg = 1; wa = 5'd3; dreg = 32'h1234; whilo = 1;
    cycle();
    chk("post_rst_we", s_we, 1'b0);

    // ALU + HI-only pass-through
    clear_inputs();
    valid = 1; wreg = 1; wa = 5'd8; dreg = 32'hA5A5_0001; whi = 1;
    hilo = 64'h1111_2222_3333_4444;
    cycle();
    chk("alu_we", s_we, 1'b1);
    chk("alu_wa", s_wa, 5'd8);
    chk("alu_wd", s_wd, 32'hA5A5_0001);
    chk("alu_hi", s_hi, 32'h1111_2222);
    chk("alu_lo_we", s_lo_we, 1'b0);
    chk("alu_stall", s_stall, 1'b0);

    // lb, sign-extended, response three cycles after entry
    set_load(5'd5, 4'b0100, 1'b0);
    stall_cnt = 0;
    cycle(); stall_cnt += int'(s_stall);
    clear_inputs();
    cycle(); stall_cnt += int'(s_stall);
    cycle(); stall_cnt += int'(s_stall);
    ok = 1; rdata = 32'h1234_80FF;
    cycle(); stall_cnt += int'(s_stall);
    clear_inputs();
    cycle();
    chk("lb_stall_cycles", stall_cnt, 4);
    chk("lb_we", s_we, 1'b1);
    chk("lb_wa", s_wa, 5'd5);
    chk("lb_wd", s_wd, 32'hFFFF_FF80);
    cycle();
    chk("lb_one_shot", s_we, 1'b0);

    // lhu with same-cycle response
    set_load(5'd9, 4'b0011, 1'b1);
    ok = 1; rdata = 32'hBEEF_0000;
    cycle();
    clear_inputs();
    cycle();
    chk("lhu_state", s_state, 2'd2);
    chk("lhu_wd", s_wd, 32'h0000_BEEF);

    // flush while waiting -> drain
    set_load(5'd7, 4'b1111, 1'b0);
    cycle();
    clear_inputs();
    cycle();
    flush = 1;
    cycle();
    flush = 0;
    cycle();
    chk("drain_state", s_state, 2'd3);
    ok = 1; rdata = 32'hDEAD_BEEF;
    cycle();
    chk("drain_we", s_we, 1'b0);
    clear_inputs();
    cycle();
    chk("drain_exit", s_state, 2'd0);

    // reset while waiting
    set_load(5'd4, 4'b1111, 1'b0);
    cycle();
    clear_inputs();
    cycle();
    rst = 1;
    cycle();
    rst = 0; ok = 1; rdata = 32'hCAFE_F00D;
    cycle();
    chk("rstw_we", s_we, 1'b0);
    chk("rstw_stall", s_stall, 1'b0);
    ok = 0;
    cycle();
    chk("rstw_idle", s_state, 2'd0);

    // unlisted byte-select
    set_load(5'd6, 4'b0110, 1'b0);
    ok = 1; rdata = 32'hFFFF_FFFF;
    cycle();
    clear_inputs();
    cycle();
    chk("dre_bad_we", s_we, 1'b1);
    chk("dre_bad_wd", s_wd, 32'h0);

    // flush in COMMIT, then flush of an IDLE ALU op
    set_load(5'd2, 4'b1000, 1'b1);
    ok = 1; rdata = 32'h0000_0081;
    cycle();
    clear_inputs();
    flush = 1;
    cycle();
    chk("commit_flush_we", s_we, 1'b0);
    valid = 1; wreg = 1; wa = 5'd1; whilo = 1; hilo = 64'h5;
    cycle();
    chk("idle_flush_we", s_we, 1'b0);
    chk("idle_flush_hi", s_hi_we, 1'b0);

    // random traffic
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom % 4) != 0;
      mreg  = ($urandom % 3) == 0;
      wreg  = $urandom % 2;
      wa    = $urandom;
      dreg  = $urandom;
      dre   = dre_tab[$urandom % 8];
      msext = $urandom % 2;
      hilo  = {$urandom, $urandom};
      whilo = ($urandom % 4) == 0;
      whi   = ($urandom % 4) == 0;
      wlo   = ($urandom % 4) == 0;
      ok    = ($urandom % 3) == 0;
      rdata = $urandom;
      flush = ($urandom % 10) == 0;
      if (!m_wait && !m_drain && !m_commit && valid && mreg) flush = 0;
      rst   = ($urandom % 50) == 0;
      cycle();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
